// File: rtl/bp_btb_pkg.sv
// Shared types for the branch target buffer: counter encoding, default geometry
// and the entry layout at the default geometry.
package bp_btb_pkg;

  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned BTB_XLEN    = 32;
  localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int unsigned BTB_TAG_W   = BTB_XLEN - BTB_IDX_W - 2;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  typedef struct packed {
    logic                 valid;
    logic                 cond;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_XLEN-1:0]  target;
    logic [1:0]           cnt;
  } btb_entry_t;

endpackage

// File: rtl/bp_btb_if.sv
// Lookup/training/flush bundle between the pipeline controller (master) and the BTB (slave).
interface bp_btb_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] if_pc_i;
  logic            pred_hit_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_next_pc_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_cond_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic            upd_mispredict_i;
  logic            flush_i;
  logic [31:0]     mispred_cnt_o;

  modport master (
    output if_pc_i, upd_valid_i, upd_pc_i, upd_cond_i, upd_taken_i,
           upd_target_i, upd_mispredict_i, flush_i,
    input  pred_hit_o, pred_taken_o, pred_next_pc_o, mispred_cnt_o
  );

  modport slave (
    input  if_pc_i, upd_valid_i, upd_pc_i, upd_cond_i, upd_taken_i,
           upd_target_i, upd_mispredict_i, flush_i,
    output pred_hit_o, pred_taken_o, pred_next_pc_o, mispred_cnt_o
  );
endinterface

// File: rtl/bp_btb_sat_cnt2.sv
// 2-bit saturating direction counter step; purely combinational so a BHT can reuse it.
module sat_cnt2
  import bp_btb_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_taken) begin
      if (i_cnt != CNT_ST) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != CNT_SNT) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/bp_btb.sv
// Tagged, flop-based branch target buffer with 2-bit direction counters,
// whole-table flush and a free-running mispredict counter.
module bp_btb
  import bp_btb_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES,
  parameter int unsigned XLEN    = BTB_XLEN
) (
  input  logic   clk,
  input  logic   rst_n,
  bp_btb_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  // Same layout as btb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic             cond;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       cnt;
  } entry_t;

  entry_t      r_table [ENTRIES];
  logic [31:0] r_mispred_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  entry_t           w_lk;
  logic             w_lk_hit;
  logic             w_lk_taken;

  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  entry_t           w_up;
  entry_t           w_up_next;
  logic             w_up_hit;
  logic             w_up_we;
  logic [1:0]       w_cnt_next;
  logic             w_unused_pc_lsb;

  assign w_lk_idx   = bus.if_pc_i[IDX_W+1:2];
  assign w_lk_tag   = bus.if_pc_i[XLEN-1:IDX_W+2];
  assign w_lk       = r_table[w_lk_idx];
  assign w_lk_hit   = w_lk.valid && (w_lk.tag == w_lk_tag);
  assign w_lk_taken = w_lk_hit && (!w_lk.cond || w_lk.cnt[1]);

  assign bus.pred_hit_o     = w_lk_hit;
  assign bus.pred_taken_o   = w_lk_taken;
  assign bus.pred_next_pc_o = w_lk_taken ? w_lk.target : bus.if_pc_i + XLEN'(4);
  assign bus.mispred_cnt_o  = r_mispred_cnt;

  assign w_up_idx        = bus.upd_pc_i[IDX_W+1:2];
  assign w_up_tag        = bus.upd_pc_i[XLEN-1:IDX_W+2];
  assign w_up            = r_table[w_up_idx];
  assign w_up_hit        = w_up.valid && (w_up.tag == w_up_tag);
  assign w_unused_pc_lsb = ^bus.upd_pc_i[1:0];

  sat_cnt2 u_sat_cnt2 (
    .i_cnt   (w_up.cnt),
    .i_taken (bus.upd_taken_i),
    .o_cnt   (w_cnt_next)
  );

  always_comb begin
    w_up_next = w_up;
    w_up_we   = 1'b0;
    if (bus.upd_valid_i) begin
      if (w_up_hit) begin
        w_up_we = 1'b1;
        if (bus.upd_cond_i) begin
          w_up_next.cnt = w_cnt_next;
          if (bus.upd_taken_i) w_up_next.target = bus.upd_target_i;
        end else begin
          w_up_next.target = bus.upd_target_i;
          w_up_next.cnt    = CNT_ST;
        end
      end else if (bus.upd_taken_i) begin
        w_up_we          = 1'b1;
        w_up_next.valid  = 1'b1;
        w_up_next.cond   = bus.upd_cond_i;
        w_up_next.tag    = w_up_tag;
        w_up_next.target = bus.upd_target_i;
        w_up_next.cnt    = bus.upd_cond_i ? CNT_WT : CNT_ST;
      end
    end
  end

  // Flush only drops valid bits; a concurrent update is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_table[i] <= '0;
    end else if (bus.flush_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_table[i].valid <= 1'b0;
    end else if (w_up_we) begin
      r_table[w_up_idx] <= w_up_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mispred_cnt <= '0;
    end else if (bus.upd_valid_i && bus.upd_mispredict_i) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bp_btb.sv
// Directed bench for bp_btb: lookup, counter training, aliasing, flush and mispredict count.
module tb_bp_btb;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bp_btb_if #(.XLEN(32)) bus ();

  bp_btb #(.ENTRIES(16), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_upd();
    bus.upd_valid_i      = 1'b0;
    bus.upd_pc_i         = '0;
    bus.upd_cond_i       = 1'b0;
    bus.upd_taken_i      = 1'b0;
    bus.upd_target_i     = '0;
    bus.upd_mispredict_i = 1'b0;
    bus.flush_i          = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic cond, input logic taken,
                           input logic [31:0] target);
    bus.upd_valid_i  = 1'b1;
    bus.upd_pc_i     = pc;
    bus.upd_cond_i   = cond;
    bus.upd_taken_i  = taken;
    bus.upd_target_i = target;
    step();
    clear_upd();
  endtask

  task automatic test_reset();
    clear_upd();
    bus.if_pc_i = 32'h0000_0100;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin errors++; $display("FAIL reset_hit got=%0b exp=0", bus.pred_hit_o); end
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_taken got=%0b exp=0", bus.pred_taken_o); end
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0104) begin errors++; $display("FAIL reset_next got=%h exp=00000104", bus.pred_next_pc_o); end
    checks++; if (bus.mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_mispred got=%0d exp=0", bus.mispred_cnt_o); end
    bus.if_pc_i = 32'hFFFF_FFFC;
    #1;
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next got=%h exp=00000000", bus.pred_next_pc_o); end
  endtask

  task automatic test_alloc();
    bus.if_pc_i      = 32'h0000_0100;
    bus.upd_valid_i  = 1'b1;
    bus.upd_pc_i     = 32'h0000_0100;
    bus.upd_cond_i   = 1'b1;
    bus.upd_taken_i  = 1'b1;
    bus.upd_target_i = 32'h0000_0200;
    #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin errors++; $display("FAIL no_bypass_hit got=%0b exp=0", bus.pred_hit_o); end
    step();
    clear_upd();
    #1;
    checks++; if (bus.pred_hit_o !== 1'b1) begin errors++; $display("FAIL alloc_hit got=%0b exp=1", bus.pred_hit_o); end
    checks++; if (bus.pred_taken_o !== 1'b1) begin errors++; $display("FAIL alloc_taken got=%0b exp=1", bus.pred_taken_o); end
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0200) begin errors++; $display("FAIL alloc_next got=%h exp=00000200", bus.pred_next_pc_o); end
    checks++; if (dut.r_table[0].cnt !== 2'b10) begin errors++; $display("FAIL alloc_cnt got=%b exp=10", dut.r_table[0].cnt); end
  endtask

  task automatic test_counter();
    logic [1:0] exp_nt [3];
    logic [1:0] exp_t  [3];
    exp_nt = '{2'b01, 2'b00, 2'b00};
    exp_t  = '{2'b01, 2'b10, 2'b11};
    bus.if_pc_i = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      do_update(32'h0000_0100, 1'b1, 1'b0, 32'h0000_0DEC);
      checks++; if (dut.r_table[0].cnt !== exp_nt[i]) begin errors++; $display("FAIL nt_cnt%0d got=%b exp=%b", i, dut.r_table[0].cnt, exp_nt[i]); end
    end
    checks++; if (bus.pred_hit_o !== 1'b1) begin errors++; $display("FAIL nt_hit got=%0b exp=1", bus.pred_hit_o); end
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL nt_taken got=%0b exp=0", bus.pred_taken_o); end
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0104) begin errors++; $display("FAIL nt_next got=%h exp=00000104", bus.pred_next_pc_o); end
    checks++; if (dut.r_table[0].target !== 32'h0000_0200) begin errors++; $display("FAIL nt_target_kept got=%h exp=00000200", dut.r_table[0].target); end
    for (int i = 0; i < 3; i++) begin
      do_update(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200);
      checks++; if (dut.r_table[0].cnt !== exp_t[i]) begin errors++; $display("FAIL t_cnt%0d got=%b exp=%b", i, dut.r_table[0].cnt, exp_t[i]); end
    end
    do_update(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0204);
    checks++; if (dut.r_table[0].cnt !== 2'b11) begin errors++; $display("FAIL t_sat got=%b exp=11", dut.r_table[0].cnt); end
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0204) begin errors++; $display("FAIL t_retarget got=%h exp=00000204", bus.pred_next_pc_o); end
  endtask

  task automatic test_alias();
    do_update(32'h0000_0140, 1'b0, 1'b1, 32'h0000_0300);
    bus.if_pc_i = 32'h0000_0100;
    #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin errors++; $display("FAIL alias_old_hit got=%0b exp=0", bus.pred_hit_o); end
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0104) begin errors++; $display("FAIL alias_old_next got=%h exp=00000104", bus.pred_next_pc_o); end
    bus.if_pc_i = 32'h0000_0140;
    #1;
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0300) begin errors++; $display("FAIL alias_new_next got=%h exp=00000300", bus.pred_next_pc_o); end
    // Not-taken miss on the same index must leave 0x140 in place.
    do_update(32'h0000_0180, 1'b1, 1'b0, 32'h0000_0900);
    checks++; if (bus.pred_hit_o !== 1'b1) begin errors++; $display("FAIL nt_miss_nowrite got=%0b exp=1", bus.pred_hit_o); end
  endtask

  task automatic test_flush();
    do_update(32'h0000_0080, 1'b0, 1'b1, 32'h0000_0400);
    bus.if_pc_i = 32'h0000_0080;
    #1;
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0400) begin errors++; $display("FAIL jal_next got=%h exp=00000400", bus.pred_next_pc_o); end
    bus.flush_i      = 1'b1;
    bus.upd_valid_i  = 1'b1;
    bus.upd_pc_i     = 32'h0000_0084;
    bus.upd_cond_i   = 1'b0;
    bus.upd_taken_i  = 1'b1;
    bus.upd_target_i = 32'h0000_0500;
    #1;
    checks++; if (bus.pred_hit_o !== 1'b1) begin errors++; $display("FAIL flush_cycle_hit got=%0b exp=1", bus.pred_hit_o); end
    step();
    clear_upd();
    #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin errors++; $display("FAIL post_flush_hit got=%0b exp=0", bus.pred_hit_o); end
    bus.if_pc_i = 32'h0000_0084;
    #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin errors++; $display("FAIL flush_drop_upd got=%0b exp=0", bus.pred_hit_o); end
    checks++; if (bus.pred_next_pc_o !== 32'h0000_0088) begin errors++; $display("FAIL flush_drop_next got=%h exp=00000088", bus.pred_next_pc_o); end
  endtask

  task automatic test_mispred();
    for (int i = 0; i < 5; i++) begin
      bus.upd_mispredict_i = 1'b1;
      do_update(32'h0000_0600, 1'b1, 1'b0, 32'h0000_0000);
    end
    bus.upd_mispredict_i = 1'b1;
    step();
    clear_upd();
    checks++; if (bus.mispred_cnt_o !== 32'd5) begin errors++; $display("FAIL mispred_cnt got=%0d exp=5", bus.mispred_cnt_o); end
    force dut.r_mispred_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_mispred_cnt;
    #1;
    bus.upd_mispredict_i = 1'b1;
    do_update(32'h0000_0600, 1'b1, 1'b0, 32'h0000_0000);
    checks++; if (bus.mispred_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mispred_max got=%h exp=ffffffff", bus.mispred_cnt_o); end
    bus.upd_mispredict_i = 1'b1;
    do_update(32'h0000_0600, 1'b1, 1'b0, 32'h0000_0000);
    checks++; if (bus.mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL mispred_wrap got=%h exp=00000000", bus.mispred_cnt_o); end
  endtask

  task automatic test_reset_midop();
    bus.if_pc_i = 32'h0000_0100;
    do_update(32'h0000_0100, 1'b0, 1'b1, 32'h0000_0700);
    rst_n = 1'b0;
    bus.upd_valid_i      = 1'b1;
    bus.upd_pc_i         = 32'h0000_0100;
    bus.upd_taken_i      = 1'b1;
    bus.upd_target_i     = 32'h0000_0800;
    bus.upd_mispredict_i = 1'b1;
    step();
    clear_upd();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.pred_hit_o !== 1'b0) begin errors++; $display("FAIL midrst_hit got=%0b exp=0", bus.pred_hit_o); end
    checks++; if (bus.mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL midrst_mispred got=%0d exp=0", bus.mispred_cnt_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.if_pc_i = '0;
    clear_upd();
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_flush();
    test_mispred();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_btb.md
# bp_btb

Parametrised branch target buffer with per-entry 2-bit saturating direction counters. It sits beside the pipeline controller: it predicts taken/target for the IF-stage PC and is trained by resolved control-flow outcomes from EX. It supersedes the single-bit, 16-slot target list in the controller with tagged entries, a configurable depth, and conditional and unconditional entry kinds. A flush port invalidates the whole table, and a mispredict counter is exposed for performance monitoring.

## Interface
- ENTRIES, 16, table depth; power of two, ≥2; IDX_W = $clog2(ENTRIES)
- XLEN, 32, address width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_pc_i  in  XLEN  PC being fetched
- pred_hit_o  out  1  valid entry with matching tag for if_pc_i
- pred_taken_o  out  1  predicted taken
- pred_next_pc_o  out  XLEN  predicted next fetch PC
- upd_valid_i  in  1  EX resolved a control-flow instruction this cycle
- upd_pc_i  in  XLEN  PC of resolved instruction
- upd_cond_i  in  1  1 = conditional branch (B-type), 0 = JAL/JALR
- upd_taken_i  in  1  actual direction
- upd_target_i  in  XLEN  actual target
- upd_mispredict_i  in  1  controller-detected misprediction (qualified by upd_valid_i)
- flush_i  in  1  invalidate all entries
- mispred_cnt_o  out  32  count of mispredicts, wraps

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. Entry fields: valid, cond, tag, target, cnt[1:0].
- Lookup is combinational from the registered table.
  - pred_hit_o = valid & tag match.
  - pred_taken_o = hit & (!cond | cnt[1]).
  - pred_next_pc_o = taken ? target : if_pc_i + 4, with XLEN-bit wrap.
- Update on upd_valid_i, indexed and tagged by upd_pc_i:
  - Hit, cond: cnt saturating +1 if taken, −1 if not taken (00 stays 00, 11 stays 11). Target is overwritten with upd_target_i if taken.
  - Hit, !cond: target is overwritten with upd_target_i. cnt is held at 11.
  - Miss, taken: allocate or replace the slot. valid=1, tag, target, cond = upd_cond_i, cnt = cond ? 2'b10 : 2'b11.
  - Miss, not taken: no write.
- flush_i: all valid bits are cleared. Targets and counters keep their values but are unused.
- Priority: reset > flush_i > update. An update in the same cycle as a flush is dropped.
- mispred_cnt_o increments when upd_valid_i & upd_mispredict_i. It is not affected by flush_i and wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset (clk edge with rst_n=0): all valid=0, cnt=00, target=0, tag=0, mispred_cnt_o=0.
  - After reset, for any if_pc_i: pred_hit_o=0, pred_taken_o=0, pred_next_pc_o=if_pc_i+4.
- Lookup latency is 0 cycles, combinational from if_pc_i.
- An update is written on the clk edge that samples it and is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents. There is no bypass.
- A flush takes effect at the edge. Lookups in the flush cycle still see the old table.
- Reset asserted mid-operation clears state at the next edge regardless of pending update or flush.
- No handshake. The block never stalls. The caller holds if_pc_i during pipeline hold and the output tracks it.

## Structure
- Shared package (type_pkg): btb_entry_t struct {valid, cond, tag, target, cnt}, parametrised by width via localparams. Also the counter encoding constants CNT_SNT=00, CNT_WNT=01, CNT_WT=10, CNT_ST=11.
- Sub-module sat_cnt2: pure function-style 2-bit saturating update (cnt, taken → cnt_next). It is reused by a future BHT.
- Table is flop-based: an array of btb_entry_t. No SRAM macro.

## Test plan
- Reset, then if_pc_i=0x0000_0100 → hit=0, taken=0, next_pc=0x104. mispred_cnt_o=0.
- Update pc=0x100, cond=1, taken=1, target=0x200. Next cycle lookup 0x100 → hit=1, taken=1, next_pc=0x200, cnt=10.
- Two not-taken updates at 0x100 → cnt 10→01→00 and lookup taken=0, next_pc=0x104. A third not-taken update keeps cnt=00. Three taken updates saturate cnt at 11.
- Aliasing with ENTRIES=16: train 0x100, then a taken update at 0x140 (same index, different tag), target 0x300. Lookup 0x100 → hit=0. Lookup 0x140 → next_pc=0x300.
- JAL at 0x80 with target 0x400, then flush_i in the same cycle as an update at 0x84 → 0x84 is not written. After the flush, lookup 0x80 → hit=0.
- 5 cycles with upd_valid_i & upd_mispredict_i, plus one with upd_mispredict_i=1 and upd_valid_i=0 → mispred_cnt_o=5. Preload near 0xFFFF_FFFF via force and check it wraps to 0.
